// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: pops A, B, opcode from the RX FIFO, runs the ALU,
// and pushes the result to the TX FIFO.
module uart_alu_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_empty,
  output logic               o_rx_read,
  input  logic               i_tx_full,
  output logic               o_tx_write,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    PUSH
  } state_t;

  state_t             state;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] res_q;
  logic               in_get;
  logic               pop;
  logic               push;

  assign in_get = (state == GET_A) ||
                  (state == GET_B) ||
                  (state == GET_OP);
  assign pop    = in_get & ~i_rx_empty;
  assign push   = (state == PUSH) & ~i_tx_full;

  assign o_rx_read  = pop;
  assign o_tx_write = push;
  assign o_done     = push;
  assign o_busy     = (state != GET_A);
  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = res_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= GET_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        GET_A: begin
          if (pop) begin
            a_q   <= i_rx_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (pop) begin
            b_q   <= i_rx_data;
            state <= GET_OP;
          end
        end
        GET_OP: begin
          if (pop) begin
            op_q  <= i_rx_data[NB_OP-1:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q <= i_alu_result;
          state <= PUSH;
        end
        PUSH: begin
          if (push) state <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: directed and randomized checks of uart_alu_ctrl
// against a FIFO/ALU environment and a per-transaction result model.
module tb_uart_alu_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_read;
  logic       tx_full;
  logic       tx_write;
  logic [7:0] tx_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_res;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  int         pops   = 0;
  int         cyc    = 0;
  int         tx_n   = 0;
  logic [7:0] tx_log [0:127];
  int         tx_cyc [0:127];

  function automatic logic [7:0] alu(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return $signed(a) >>> b[2:0];
      default: return a ^ b ^ 8'h5A;
    endcase
  endfunction

  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = mem[rd_ptr];
  assign alu_res  = alu(alu_a, alu_b, alu_op);

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_empty  (rx_empty),
    .o_rx_read   (rx_read),
    .i_tx_full   (tx_full),
    .o_tx_write  (tx_write),
    .o_tx_data   (tx_data),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .i_alu_result(alu_res),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO environment: pop on read strobe, log every push
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_read && !rx_empty) begin
      rd_ptr <= rd_ptr + 8'd1;
      pops   <= pops + 1;
    end
    if (tx_write && !tx_full && tx_n < 128) begin
      tx_log[tx_n] <= tx_data;
      tx_cyc[tx_n] <= cyc;
      tx_n         <= tx_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int strobes;
    int busy_lo;
    int base;
    int pbase;
    int budget;
    int overlap;
    logic [7:0] ra, rb, ro;
    logic [31:0] rnd;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [5:0] ops [0:8];

    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
            6'h27, 6'h02, 6'h03, 6'h3F};
    rst_n   = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset
    repeat (3) tick();
    chk("rst_rx_read", rx_read, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_regs", {alu_a, alu_b, 2'b0, alu_op, tx_data}, 0);
    rst_n = 1'b1;
    strobes = 0;
    busy_lo = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      strobes += int'(rx_read) + int'(tx_write) + int'(done);
      busy_lo += int'(busy);
    end
    chk("idle_strobes", strobes, 0);
    chk("idle_busy", busy_lo, 0);

    // single ADD
    put(8'h05); put(8'h03); put(8'h20);
    #1;
    chk("add_pop1", rx_read, 1);
    tick();
    chk("add_pop2", rx_read, 1);
    chk("add_busy", busy, 1);
    chk("add_a_early", alu_a, 8'h05);
    tick();
    chk("add_pop3", rx_read, 1);
    tick();
    chk("add_exec_rd", {rx_read, tx_write}, 0);
    chk("add_regs", {alu_a, alu_b, 2'b0, alu_op}, 24'h050320);
    tick();
    chk("add_push", {tx_write, done}, 2'b11);
    chk("add_data", tx_data, 8'h08);
    tick();
    chk("add_after", {tx_write, busy}, 0);

    // RX starvation in GET_B
    put(8'hFF);
    tick();
    strobes = 0;
    busy_lo = 0;
    for (int i = 0; i < 7; i++) begin
      strobes += int'(rx_read) + int'(tx_write);
      busy_lo += int'(!busy) + int'(alu_a != 8'hFF);
      tick();
    end
    chk("starve_strobes", strobes, 0);
    chk("starve_hold", busy_lo, 0);
    put(8'h01);
    tick();
    put(8'h22);
    #1;
    chk("starve_op_pop", rx_read, 1);
    tick();
    chk("starve_exec", tx_write, 0);
    tick();
    chk("starve_push", {tx_write, tx_data}, {1'b1, 8'hFE});
    tick();

    // TX backpressure from PUSH entry
    put(8'h05); put(8'h03); put(8'h20);
    tick(); tick(); tick();
    tx_full = 1'b1;
    base = tx_n;
    strobes = 0;
    busy_lo = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      strobes += int'(tx_write) + int'(done);
      busy_lo += int'(tx_data != 8'h08) + int'(!busy);
    end
    chk("bp_no_write", strobes, 0);
    chk("bp_hold", busy_lo, 0);
    tx_full = 1'b0;
    #1;
    chk("bp_release", {tx_write, tx_data}, {1'b1, 8'h08});
    tick();
    chk("bp_after", tx_write, 0);
    chk("bp_one_write", tx_n - base, 1);

    // back-to-back
    base  = tx_n;
    pbase = pops;
    put(8'h05); put(8'h03); put(8'h20);
    put(8'h0A); put(8'h04); put(8'h22);
    repeat (12) tick();
    chk("b2b_count", tx_n - base, 2);
    chk("b2b_pops", pops - pbase, 6);
    chk("b2b_r0", tx_log[base], 8'h08);
    chk("b2b_r1", tx_log[base+1], 8'h06);
    chk("b2b_gap", tx_cyc[base+1] - tx_cyc[base], 5);

    // reset during EXEC
    base = tx_n;
    put(8'h05); put(8'h03); put(8'h20);
    tick(); tick(); tick();
    chk("mid_exec_op", alu_op, 6'h20);
    rst_n = 1'b0;
    #1;
    chk("mid_regs", {alu_a, alu_b, 2'b0, alu_op, tx_data}, 0);
    chk("mid_outs", {tx_write, busy, done}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mid_no_push", tx_n - base, 0);
    put(8'h0A); put(8'h04); put(8'hE2);
    tick(); tick(); tick();
    chk("mid_op_mask", alu_op, 6'h22);
    tick();
    chk("mid_fresh", {tx_write, tx_data}, {1'b1, 8'h06});
    tick();
    chk("mid_fresh_cnt", tx_n - base, 1);

    // randomized traffic with gaps and backpressure
    base = tx_n;
    for (int t = 0; t < 20; t++) begin
      rnd = $urandom;
      ra  = rnd[7:0];
      rb  = rnd[15:8];
      ro  = {rnd[17:16], ops[$urandom_range(0, 8)]};
      src_q.push_back(ra);
      src_q.push_back(rb);
      src_q.push_back(ro);
      exp_q.push_back(alu(ra, rb, ro[5:0]));
    end
    overlap = 0;
    while (src_q.size() > 0) begin
      if ($urandom_range(0, 3) != 0) put(src_q.pop_front());
      tx_full = ($urandom_range(0, 3) == 0);
      #1;
      overlap += int'(rx_read && tx_write);
      tick();
    end
    tx_full = 1'b0;
    budget = 0;
    while (tx_n < base + 20 && budget < 500) begin
      overlap += int'(rx_read && tx_write);
      tick();
      budget++;
    end
    chk("rnd_count", tx_n - base, 20);
    chk("rnd_overlap", overlap, 0);
    for (int i = 0; i < 20; i++) begin
      if (base + i < tx_n)
        chk($sformatf("rnd_res%0d", i), tx_log[base+i], exp_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
